// File: rtl/udp_tx_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AXIS TX port of the UDP/IP core
// between G_NUM_REQ sources, with per-packet metadata latching and pacing gaps.
module udp_tx_stream_arbiter #(
  parameter int unsigned G_NUM_REQ         = 4,
  parameter int unsigned G_AXIS_DATA_WIDTH = 1024,
  parameter int unsigned G_GAP_WIDTH       = 16
) (
  input  logic                                       axis_streaming_data_clk,
  input  logic                                       axis_streaming_rst,
  input  logic                                       arb_enable,
  input  logic [G_GAP_WIDTH-1:0]                     arb_gap_cycles,
  input  logic [G_NUM_REQ*G_AXIS_DATA_WIDTH-1:0]     s_tdata,
  input  logic [G_NUM_REQ*G_AXIS_DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [G_NUM_REQ-1:0]                       s_tvalid,
  input  logic [G_NUM_REQ-1:0]                       s_tlast,
  input  logic [G_NUM_REQ-1:0]                       s_tuser,
  output logic [G_NUM_REQ-1:0]                       s_tready,
  input  logic [G_NUM_REQ*32-1:0]                    s_dest_ip,
  input  logic [G_NUM_REQ*16-1:0]                    s_dest_port,
  input  logic [G_NUM_REQ*16-1:0]                    s_src_port,
  input  logic [G_NUM_REQ*16-1:0]                    s_pkt_length,
  output logic [G_AXIS_DATA_WIDTH-1:0]               m_tdata,
  output logic [G_AXIS_DATA_WIDTH/8-1:0]             m_tkeep,
  output logic                                       m_tvalid,
  output logic                                       m_tlast,
  output logic                                       m_tuser,
  input  logic                                       m_tready,
  output logic [31:0]                                m_dest_ip,
  output logic [15:0]                                m_dest_port,
  output logic [15:0]                                m_src_port,
  output logic [15:0]                                m_pkt_length,
  output logic [2:0]                                 arb_grant_id,
  output logic                                       arb_busy,
  output logic [31:0]                                arb_pkt_count
);

  localparam int unsigned DW = G_AXIS_DATA_WIDTH;
  localparam int unsigned KW = G_AXIS_DATA_WIDTH / 8;
  localparam int unsigned NR = G_NUM_REQ;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [2:0]             last_grant;
  logic [2:0]             rr_cand;
  logic [2:0]             sel_idx;
  logic                   sel_found;
  logic                   grant_now;
  logic                   pkt_done;
  logic [G_GAP_WIDTH-1:0] gap_cnt;
  logic [31:0]            sel_dest_ip;
  logic [15:0]            sel_dest_port;
  logic [15:0]            sel_src_port;
  logic [15:0]            sel_pkt_length;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_cand   = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      rr_cand = 3'((32'(last_grant) + k) % NR);
      for (int unsigned j = 0; j < NR; j++) begin
        if (!sel_found && (rr_cand == 3'(j)) && s_tvalid[j]) begin
          sel_found = 1'b1;
          sel_idx   = rr_cand;
        end
      end
    end
  end

  always_comb begin
    sel_dest_ip    = '0;
    sel_dest_port  = '0;
    sel_src_port   = '0;
    sel_pkt_length = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (sel_idx == 3'(j)) begin
        sel_dest_ip    = s_dest_ip[j*32 +: 32];
        sel_dest_port  = s_dest_port[j*16 +: 16];
        sel_src_port   = s_src_port[j*16 +: 16];
        sel_pkt_length = s_pkt_length[j*16 +: 16];
      end
    end
  end

  // Granted slice passes straight through while in PASS.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    s_tready = '0;
    if (state == S_PASS) begin
      for (int unsigned j = 0; j < NR; j++) begin
        if (arb_grant_id == 3'(j)) begin
          m_tdata     = s_tdata[j*DW +: DW];
          m_tkeep     = s_tkeep[j*KW +: KW];
          m_tvalid    = s_tvalid[j];
          m_tlast     = s_tlast[j];
          m_tuser     = s_tuser[j];
          s_tready[j] = m_tready;
        end
      end
    end
  end

  assign grant_now = (state == S_IDLE) && arb_enable && sel_found;
  assign pkt_done  = (state == S_PASS) && m_tvalid && m_tready && m_tlast;
  assign arb_busy  = (state != S_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (grant_now) state_next = S_PASS;
      S_PASS: if (pkt_done) state_next = (arb_gap_cycles != '0) ? S_GAP : S_IDLE;
      S_GAP:  if (gap_cnt == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_streaming_data_clk) begin
    if (axis_streaming_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant/metadata latch, packet counter and gap down-counter.
  always_ff @(posedge axis_streaming_data_clk) begin
    if (axis_streaming_rst) begin
      last_grant    <= 3'(NR - 1);
      arb_grant_id  <= '0;
      m_dest_ip     <= '0;
      m_dest_port   <= '0;
      m_src_port    <= '0;
      m_pkt_length  <= '0;
      arb_pkt_count <= '0;
      gap_cnt       <= '0;
    end else begin
      if (grant_now) begin
        last_grant   <= sel_idx;
        arb_grant_id <= sel_idx;
        m_dest_ip    <= sel_dest_ip;
        m_dest_port  <= sel_dest_port;
        m_src_port   <= sel_src_port;
        m_pkt_length <= sel_pkt_length;
      end
      if (pkt_done) begin
        arb_pkt_count <= arb_pkt_count + 32'd1;
        gap_cnt       <= arb_gap_cycles - G_GAP_WIDTH'(1);
      end else if ((state == S_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - G_GAP_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_stream_arbiter.sv
// Scoreboard bench for udp_tx_stream_arbiter: per-requester expected-beat queues
// filled when packets are queued, drained as beats leave the master port.
module tb_udp_tx_stream_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 64;
  localparam int unsigned KW   = DW / 8;
  localparam int unsigned GW   = 16;

  logic                 clk = 1'b0;
  logic                 axis_streaming_rst;
  logic                 arb_enable;
  logic [GW-1:0]        arb_gap_cycles;
  logic [NREQ*DW-1:0]   s_tdata;
  logic [NREQ*KW-1:0]   s_tkeep;
  logic [NREQ-1:0]      s_tvalid, s_tlast, s_tuser, s_tready;
  logic [NREQ*32-1:0]   s_dest_ip;
  logic [NREQ*16-1:0]   s_dest_port, s_src_port, s_pkt_length;
  logic [DW-1:0]        m_tdata;
  logic [KW-1:0]        m_tkeep;
  logic                 m_tvalid, m_tlast, m_tuser, m_tready;
  logic [31:0]          m_dest_ip;
  logic [15:0]          m_dest_port, m_src_port, m_pkt_length;
  logic [2:0]           arb_grant_id;
  logic                 arb_busy;
  logic [31:0]          arb_pkt_count;

  always #5 clk = ~clk;

  udp_tx_stream_arbiter #(
    .G_NUM_REQ(NREQ), .G_AXIS_DATA_WIDTH(DW), .G_GAP_WIDTH(GW)
  ) dut (
    .axis_streaming_data_clk(clk), .axis_streaming_rst(axis_streaming_rst),
    .arb_enable(arb_enable), .arb_gap_cycles(arb_gap_cycles),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tready(s_tready), .s_dest_ip(s_dest_ip),
    .s_dest_port(s_dest_port), .s_src_port(s_src_port), .s_pkt_length(s_pkt_length),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tready(m_tready), .m_dest_ip(m_dest_ip),
    .m_dest_port(m_dest_port), .m_src_port(m_src_port), .m_pkt_length(m_pkt_length),
    .arb_grant_id(arb_grant_id), .arb_busy(arb_busy), .arb_pkt_count(arb_pkt_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    logic [31:0]   ip;
    logic [15:0]   dp;
    logic [15:0]   sp;
    logic [15:0]   len;
  } exp_t;

  exp_t            exp_q [NREQ][$];
  int              pend  [NREQ][$];
  int              beat    [NREQ];
  int              cur_ser [NREQ];
  int              add_ser [NREQ];
  int              beats_by[NREQ];
  logic [NREQ-1:0] hs = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic          drv_rst    = 1'b1;
  logic          drv_enable = 1'b1;
  logic [GW-1:0] drv_gap    = '0;
  int            rdy_mode   = 0;

  bit in_pkt, saw_tlast;
  int idle_run, busy_run, stray;
  int grant_q[$], gap_q[$], busyr_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input int i, input int p, input int b, input int len);
    exp_t e;
    e.data = {8'(i), 24'(p), 32'(b)};
    e.keep = (b == len - 1) ? 8'h0F : 8'hFF;
    e.last = (b == len - 1);
    e.user = (b == 0);
    e.ip   = {8'd192, 8'd168, 8'(i), 8'(p)};
    e.dp   = 16'(1000 + i);
    e.sp   = 16'(2000 + p);
    e.len  = 16'(len * 8);
    return e;
  endfunction

  task automatic add_pkt(input int i, input int len);
    pend[i].push_back(len);
    for (int b = 0; b < len; b++) exp_q[i].push_back(mk_exp(i, add_ser[i], b, len));
    add_ser[i]++;
  endtask

  task automatic clear_mon();
    grant_q.delete(); gap_q.delete(); busyr_q.delete();
    in_pkt = 0; saw_tlast = 0; idle_run = 0; busy_run = 0; stray = 0;
    for (int i = 0; i < NREQ; i++) beats_by[i] = 0;
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      pend[i].delete(); exp_q[i].delete();
      beat[i] = 0; cur_ser[i] = add_ser[i];
    end
    hs = '0;
  endtask

  function automatic bit drained();
    bit d = 1'b1;
    for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0 || exp_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic sb_compare();
    int   g;
    bit   ok;
    exp_t e;
    g  = int'(arb_grant_id);
    ok = (g < NREQ) ? (exp_q[g].size() != 0) : 1'b0;
    check("sb_beat_expected", 64'(ok), 64'd1);
    if (ok) begin
      e = exp_q[g].pop_front();
      beats_by[g]++;
      check("tdata", 64'(m_tdata), 64'(e.data));
      check("tkeep_last_user", 64'({m_tkeep, m_tlast, m_tuser}), 64'({e.keep, e.last, e.user}));
      check("meta_ip_ports", {m_dest_ip, m_dest_port, m_src_port}, {e.ip, e.dp, e.sp});
      check("meta_len", 64'(m_pkt_length), 64'(e.len));
    end
  endtask

  // One cycle: advance sources on last handshake, drive, then observe mid-cycle.
  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        beat[i]++;
        if (beat[i] == pend[i][0]) begin
          void'(pend[i].pop_front());
          beat[i] = 0;
          cur_ser[i]++;
        end
      end
    end
    hs = '0;
    axis_streaming_rst = drv_rst;
    arb_enable         = drv_enable;
    arb_gap_cycles     = drv_gap;
    m_tready           = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() != 0) begin
        e = mk_exp(i, cur_ser[i], beat[i], pend[i][0]);
        s_tdata[i*DW +: DW]      = e.data;
        s_tkeep[i*KW +: KW]      = e.keep;
        s_tvalid[i]              = 1'b1;
        s_tlast[i]               = e.last;
        s_tuser[i]               = e.user;
        // metadata only guaranteed until the first beat is accepted
        s_dest_ip[i*32 +: 32]    = (beat[i] == 0) ? e.ip  : 32'hDEAD_BEEF;
        s_dest_port[i*16 +: 16]  = (beat[i] == 0) ? e.dp  : 16'hBAD0;
        s_src_port[i*16 +: 16]   = (beat[i] == 0) ? e.sp  : 16'hBAD1;
        s_pkt_length[i*16 +: 16] = (beat[i] == 0) ? e.len : 16'hFFFF;
      end else begin
        s_tdata[i*DW +: DW] = '0; s_tkeep[i*KW +: KW] = '0;
        s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tuser[i] = 1'b0;
        s_dest_ip[i*32 +: 32] = '0; s_dest_port[i*16 +: 16] = '0;
        s_src_port[i*16 +: 16] = '0; s_pkt_length[i*16 +: 16] = '0;
      end
    end
    #1;
    if (axis_streaming_rst) begin
      in_pkt = 0; saw_tlast = 0; idle_run = 0; busy_run = 0;
    end else begin
      hs = s_tvalid & s_tready;
      if ((s_tready & ~(4'(1) << arb_grant_id)) != '0) stray++;
      if (m_tvalid) begin
        if (!in_pkt) begin
          grant_q.push_back(int'(arb_grant_id));
          if (saw_tlast) begin gap_q.push_back(idle_run); busyr_q.push_back(busy_run); end
          in_pkt = 1;
        end
      end else begin
        idle_run++;
        if (arb_busy) busy_run++;
      end
      if (m_tvalid && m_tready) begin
        sb_compare();
        if (m_tlast) begin in_pkt = 0; saw_tlast = 1; idle_run = 0; busy_run = 0; end
      end
    end
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while (!drained() && n < budget) begin step(); n++; end
    check("drain_in_budget", 64'(drained()), 64'd1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    step(); step();
    flush();
    drv_rst = 1'b0;
    step();
    clear_mon();
  endtask

  initial begin
    int n;
    axis_streaming_rst = 1'b1; arb_enable = 1'b0; arb_gap_cycles = '0; m_tready = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    s_dest_ip = '0; s_dest_port = '0; s_src_port = '0; s_pkt_length = '0;
    for (int i = 0; i < NREQ; i++) begin beat[i] = 0; cur_ser[i] = 0; add_ser[i] = 0; end
    clear_mon();

    // reset state
    step(); step();
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_busy", 64'(arb_busy), 64'd0);
    check("rst_pkt_count", 64'(arb_pkt_count), 64'd0);
    check("rst_grant_id", 64'(arb_grant_id), 64'd0);
    check("rst_meta", {m_dest_ip, m_dest_port, m_src_port}, 64'd0);
    check("rst_tdata_keep", 64'(m_tdata) | 64'(m_tkeep), 64'd0);
    drv_rst = 1'b0;
    step();

    // two simultaneous requesters: 0 first, then 2, one idle cycle apart
    do_reset();
    add_pkt(0, 64); add_pkt(2, 64);
    run_drain(400);
    check("t1_grants", 64'(grant_q.size()), 64'd2);
    if (grant_q.size() == 2) begin
      check("t1_first", 64'(grant_q[0]), 64'd0);
      check("t1_second", 64'(grant_q[1]), 64'd2);
    end
    check("t1_gap_count", 64'(gap_q.size()), 64'd1);
    if (gap_q.size() == 1) check("t1_idle", 64'(gap_q[0]), 64'd1);
    check("t1_pkt_count", 64'(arb_pkt_count), 64'd2);
    check("t1_stray_ready", 64'(stray), 64'd0);

    // all requesters saturated with single-beat packets
    do_reset();
    for (int k = 0; k < 25; k++) for (int i = 0; i < NREQ; i++) add_pkt(i, 1);
    run_drain(1000);
    check("t2_grants", 64'(grant_q.size()), 64'd100);
    for (int k = 0; k < grant_q.size(); k++) check("t2_rr_order", 64'(grant_q[k]), 64'(k % NREQ));
    for (int i = 0; i < NREQ; i++) check("t2_share", 64'(beats_by[i]), 64'd25);
    check("t2_pkt_count", 64'(arb_pkt_count), 64'd100);

    // random backpressure on a req1 packet while others wait
    do_reset();
    rdy_mode = 1;
    add_pkt(1, 64);
    step(); step();
    add_pkt(0, 8); add_pkt(2, 8); add_pkt(3, 8);
    n = 0;
    while (pend[1].size() != 0 && n < 2000) begin step(); n++; end
    check("t3_req1_beats", 64'(beats_by[1]), 64'd64);
    check("t3_others_idle", 64'(beats_by[0] + beats_by[2] + beats_by[3]), 64'd0);
    check("t3_stray_ready", 64'(stray), 64'd0);
    run_drain(2000);
    rdy_mode = 0;
    if (grant_q.size() != 0) check("t3_first_grant", 64'(grant_q[0]), 64'd1);

    // pacing gap of 10 between back-to-back req3 packets
    do_reset();
    drv_gap = 16'd10;
    add_pkt(3, 4); add_pkt(3, 4); add_pkt(3, 4);
    run_drain(300);
    repeat (12) step();
    drv_gap = '0;
    check("t4_gaps", 64'(gap_q.size()), 64'd2);
    for (int k = 0; k < gap_q.size(); k++) check("t4_idle", 64'(gap_q[k]), 64'd11);
    for (int k = 0; k < busyr_q.size(); k++) check("t4_busy_in_gap", 64'(busyr_q[k]), 64'd10);
    check("t4_pkt_count", 64'(arb_pkt_count), 64'd3);

    // disable mid-packet: packet completes, no further grants until re-enabled
    do_reset();
    add_pkt(0, 64); add_pkt(1, 4);
    n = 0;
    while (beat[0] < 5 && n < 100) begin step(); n++; end
    drv_enable = 1'b0;
    n = 0;
    while (pend[0].size() != 0 && n < 200) begin step(); n++; end
    repeat (20) step();
    check("t5_req0_beats", 64'(beats_by[0]), 64'd64);
    check("t5_no_new_grant", 64'(grant_q.size()), 64'd1);
    check("t5_idle_valid", 64'(m_tvalid), 64'd0);
    check("t5_idle_busy", 64'(arb_busy), 64'd0);
    drv_enable = 1'b1;
    step();
    check("t5_enable_edge_valid", 64'(m_tvalid), 64'd0);
    step();
    check("t5_grant_valid", 64'(m_tvalid), 64'd1);
    check("t5_grant_id", 64'(arb_grant_id), 64'd1);
    run_drain(100);

    // reset in the middle of a req1 packet
    do_reset();
    add_pkt(1, 64);
    n = 0;
    while (beat[1] < 20 && n < 100) begin step(); n++; end
    drv_rst = 1'b1;
    step();
    flush();
    drv_rst = 1'b0;
    step();
    check("t6_valid", 64'(m_tvalid), 64'd0);
    check("t6_ready", 64'(s_tready), 64'd0);
    check("t6_pkt_count", 64'(arb_pkt_count), 64'd0);
    clear_mon();
    add_pkt(1, 4); add_pkt(0, 4);
    run_drain(100);
    check("t6_grants", 64'(grant_q.size()), 64'd2);
    if (grant_q.size() != 0) check("t6_first_grant", 64'(grant_q[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
